am4_useq: RTL and testbench
===========================

AM4_USEQ -- requirements
Module: am4_useq

Interface
REQ-001 Parameter AW, default 12: microaddress width in bits.
REQ-002 Parameter SD, default 4: return-stack depth in entries.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 s  input  2  address select: 00 µPC, 01 R/counter, 10 stack top, 11 direct input.
REQ-006 fe_n  input  1  file (stack) enable, active-low.
REQ-007 pup  input  1  stack direction: 1 push, 0 pop; meaningful only while fe_n=0.
REQ-008 ctl_n  input  1  R/counter load, active-low.
REQ-009 cte_n  input  1  R/counter decrement enable, active-low.
REQ-010 di  input  AW  direct (pipeline) address and counter load data.
REQ-011 ci  input  1  µPC increment carry-in.
REQ-012 y  output  AW  selected next microaddress, combinational.
REQ-013 cz  output  1  counter-zero flag, 1 when R/counter = 0.
REQ-014 full  output  1  1 when the stack holds SD entries.
REQ-015 empty  output  1  1 when the stack holds 0 entries.
REQ-016 ovf  output  1  sticky flag: a push was attempted while full, or a pop while empty.

Function
REQ-017 y SHALL be selected combinationally from pre-edge state: s=00 µPC, 01 R, 10 stack top, 11 di. There is zero-cycle latency from s/di to y.
REQ-018 Stack top SHALL read 0 when empty.
REQ-019 Each edge SHALL update µPC to y+ci, modulo 2^AW; 0xFFF+1 wraps to 0x000.
REQ-020 With fe_n=0 and pup=1, the edge SHALL push the pre-edge µPC, then increment the stack pointer.
REQ-021 With fe_n=0 and pup=0, the edge SHALL decrement the stack pointer.
REQ-022 With fe_n=1, the stack and pointer SHALL hold.
REQ-023 Push while full: the pointer saturates at SD, the top entry is overwritten with the pre-edge µPC, and ovf is set.
REQ-024 Pop while empty: the pointer stays 0, the stack is unchanged, and ovf is set.
REQ-025 s=10 combined with a pop SHALL drive y from the pre-pop top; the pop takes effect at the same edge.
REQ-026 With ctl_n=0, the edge SHALL load R with di; load has priority over cte_n.
REQ-027 With ctl_n=1 and cte_n=0, the edge SHALL decrement R modulo 2^AW; 0x000 becomes 0xFFF.
REQ-028 With ctl_n=1 and cte_n=1, R SHALL hold.
REQ-029 cz SHALL be combinational from registered R; it feeds the upstream test mux with zero added latency.
REQ-030 Stack, µPC and R updates SHALL be independent and may all occur on the same edge.
REQ-031 full SHALL be derived combinationally from the stack pointer (pointer = SD).
REQ-032 empty SHALL be derived combinationally from the stack pointer (pointer = 0).
REQ-033 ovf SHALL remain set until rst.

Reset
REQ-034 On rst=1 at an edge: µPC=0, R=0, stack pointer=0, all stack entries=0, ovf=0.
REQ-035 Post-reset output values SHALL be: y per s from the reset state, cz=1, empty=1, full=0.
REQ-036 rst SHALL override all simultaneous push, pop, load and decrement requests.
REQ-037 rst asserted mid-loop or mid-subroutine SHALL discard all state with no residual effect.

Structure
REQ-038 The shared package SHALL hold the AW/SD defaults and the s encoding constants (SEL_PC, SEL_RA, SEL_SP, SEL_DI).
REQ-039 The stack SHALL be a sub-module, am4_ustack: pointer, SD×AW storage, full/empty/ovf logic.
REQ-040 µPC, R/counter and the output mux SHALL reside in am4_useq.

Verification
REQ-041 Reset, s=00, ci=1, 3 edges: y steps 0x000→0x001→0x002→0x003; cz=1; empty=1.
REQ-042 Subroutine call and return: s=11, di=0x123, fe_n=0, pup=1 at µPC=0x010, ci=1. Response: next y from s=00 is 0x124. Then s=10, fe_n=0, pup=0: y=0x010 (the pushed pre-edge µPC) and empty=1 after the edge.
REQ-043 Stack overflow: 5 pushes of µPC values 1..5 → full=1 after the 4th push; ovf=1 after the 5th. Subsequent pops return 5, 3, 2, 1.
REQ-044 Counter: ctl_n=0, di=0x002, then cte_n=0 for 3 edges. Response: R=2,1,0,0xFFF; cz=1 only while R=0.
REQ-045 Priority: ctl_n=0 and cte_n=0, di=0x055 → R=0x055. Pop on empty → pointer 0, ovf=1, top reads 0.
REQ-046 Reset mid-operation: rst asserted with fe_n=0, pup=1, ctl_n=0 on the same edge → all state per REQ-034, push and load ignored.

Source files
------------

// File: rtl/am4_useq_pkg.sv
// am4_useq_pkg: shared constants for the microprogram sequencer slice.
//   AW_DEF / SD_DEF : default microaddress width and return-stack depth
//   SEL_*           : encodings of the address-select input s
//   ptr_width()     : width needed for a stack pointer that counts 0..sd
package am4_useq_pkg;

    localparam int AW_DEF = 12;
    localparam int SD_DEF = 4;

    localparam logic [1:0] SEL_PC = 2'b00;
    localparam logic [1:0] SEL_RA = 2'b01;
    localparam logic [1:0] SEL_SP = 2'b10;
    localparam logic [1:0] SEL_DI = 2'b11;

    // The pointer must represent SD itself (full), not just SD-1.
    function automatic int ptr_width(input int sd);
        return (sd < 1) ? 1 : $clog2(sd + 1);
    endfunction

endpackage

// File: rtl/am4_useq_ustack.sv
// am4_ustack: return-address stack for the sequencer.
//   clk, rst        : clock, synchronous active-high reset
//   fe_n_i, pup_i   : stack enable (active-low) and direction (1 push, 0 pop)
//   push_data_i     : value written on a push (the pre-edge uPC)
//   top_o           : current top entry, 0 when empty
//   full_o, empty_o : pointer == SD / pointer == 0
//   ovf_o           : sticky push-while-full or pop-while-empty flag
module am4_ustack
    import am4_useq_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int SD = SD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fe_n_i,
    input  logic          pup_i,
    input  logic [AW-1:0] push_data_i,
    output logic [AW-1:0] top_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          ovf_o
);

    localparam int PW = ptr_width(SD);
    localparam int IW = (SD > 1) ? $clog2(SD) : 1;

    logic [PW-1:0] sp_q;
    logic [PW-1:0] sp_d;
    logic          ovf_q;
    logic          ovf_d;
    logic [AW-1:0] mem_q [SD];
    logic          wr_en_s;
    logic [IW-1:0] wr_idx_s;
    logic [PW-1:0] top_idx_s;

    assign full_o    = (sp_q == PW'(SD));
    assign empty_o   = (sp_q == {PW{1'b0}});
    assign ovf_o     = ovf_q;
    assign top_idx_s = sp_q - PW'(1);
    assign top_o     = empty_o ? {AW{1'b0}} : mem_q[top_idx_s[IW-1:0]];

    // Next pointer, write port and overflow flag from the stack request.
    always_comb begin
        sp_d     = sp_q;
        ovf_d    = ovf_q;
        wr_en_s  = 1'b0;
        wr_idx_s = {IW{1'b0}};
        if (!fe_n_i) begin
            if (pup_i) begin
                wr_en_s = 1'b1;
                if (full_o) begin
                    // Saturate: overwrite the top entry instead of growing.
                    wr_idx_s = IW'(SD - 1);
                    ovf_d    = 1'b1;
                end else begin
                    wr_idx_s = sp_q[IW-1:0];
                    sp_d     = sp_q + PW'(1);
                end
            end else begin
                if (empty_o) begin
                    ovf_d = 1'b1;
                end else begin
                    sp_d = sp_q - PW'(1);
                end
            end
        end else begin
            sp_d = sp_q;
        end
    end

    // Stack state registers; reset clears every entry so nothing survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= {PW{1'b0}};
            ovf_q <= 1'b0;
            for (int i = 0; i < SD; i++) begin
                mem_q[i] <= {AW{1'b0}};
            end
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            if (wr_en_s) begin
                mem_q[wr_idx_s] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/am4_useq.sv
// am4_useq: microprogram sequencer (uPC, loop counter R, return stack).
//   clk, rst   : clock, synchronous active-high reset
//   s          : next-address select (uPC, R, stack top, di)
//   fe_n, pup  : stack enable / direction
//   ctl_n      : load R from di; cte_n : decrement R
//   di         : direct address and counter load data
//   ci         : uPC increment carry-in
//   y          : next microaddress (combinational from pre-edge state)
//   cz         : R == 0;  full / empty / ovf : stack status
module am4_useq
    import am4_useq_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int SD = SD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    s,
    input  logic          fe_n,
    input  logic          pup,
    input  logic          ctl_n,
    input  logic          cte_n,
    input  logic [AW-1:0] di,
    input  logic          ci,
    output logic [AW-1:0] y,
    output logic          cz,
    output logic          full,
    output logic          empty,
    output logic          ovf
);

    logic [AW-1:0] upc_q;
    logic [AW-1:0] upc_d;
    logic [AW-1:0] r_q;
    logic [AW-1:0] r_d;
    logic [AW-1:0] top_s;

    am4_ustack #(
        .AW (AW),
        .SD (SD)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .fe_n_i      (fe_n),
        .pup_i       (pup),
        .push_data_i (upc_q),
        .top_o       (top_s),
        .full_o      (full),
        .empty_o     (empty),
        .ovf_o       (ovf)
    );

    // Output address mux; reads the pre-pop top so a return sees its target.
    always_comb begin
        case (s)
            SEL_PC:  y = upc_q;
            SEL_RA:  y = r_q;
            SEL_SP:  y = top_s;
            SEL_DI:  y = di;
            default: y = upc_q;
        endcase
    end

    assign upc_d = y + AW'(ci);
    assign cz    = (r_q == {AW{1'b0}});

    // Counter next state: load beats decrement.
    always_comb begin
        r_d = r_q;
        if (!ctl_n) begin
            r_d = di;
        end else if (!cte_n) begin
            r_d = r_q - AW'(1);
        end else begin
            r_d = r_q;
        end
    end

    // uPC and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            upc_q <= {AW{1'b0}};
            r_q   <= {AW{1'b0}};
        end else begin
            upc_q <= upc_d;
            r_q   <= r_d;
        end
    end

endmodule

// File: tb/tb_am4_useq.sv
module tb_am4_useq;

    localparam int AW = 12;
    localparam int SD = 4;
    localparam int MASK = 32'hFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    s;
    logic          fe_n;
    logic          pup;
    logic          ctl_n;
    logic          cte_n;
    logic [AW-1:0] di;
    logic          ci;
    logic [AW-1:0] y;
    logic          cz;
    logic          full;
    logic          empty;
    logic          ovf;

    int checks   = 0;
    int failures = 0;

    // Behavioural reference state.
    int m_upc;
    int m_r;
    int m_stk[$];
    bit m_ovf;
    bit m_valid = 1'b0;

    am4_useq #(.AW(AW), .SD(SD)) dut (
        .clk   (clk),
        .rst   (rst),
        .s     (s),
        .fe_n  (fe_n),
        .pup   (pup),
        .ctl_n (ctl_n),
        .cte_n (cte_n),
        .di    (di),
        .ci    (ci),
        .y     (y),
        .cz    (cz),
        .full  (full),
        .empty (empty),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_top();
        return (m_stk.size() > 0) ? m_stk[m_stk.size() - 1] : 0;
    endfunction

    function automatic int m_y();
        case (s)
            2'b00:   return m_upc;
            2'b01:   return m_r;
            2'b10:   return m_top();
            default: return int'(di);
        endcase
    endfunction

    task automatic set_in(input bit r, input int sel, input bit fen, input bit pu,
                          input bit ctl, input bit cte, input int d, input bit c);
        rst = r; s = sel[1:0]; fe_n = fen; pup = pu;
        ctl_n = ctl; cte_n = cte; di = d[AW-1:0]; ci = c;
        #1;
        if (m_valid) begin
            chk("y", int'(y), m_y());
            chk("cz", int'(cz), int'(m_r == 0));
            chk("full", int'(full), int'(m_stk.size() == SD));
            chk("empty", int'(empty), int'(m_stk.size() == 0));
            chk("ovf", int'(ovf), int'(m_ovf));
        end
    endtask

    // Advance one edge and apply the architectural rules to the model.
    task automatic tick();
        int ny;
        @(posedge clk);
        if (rst) begin
            m_upc = 0; m_r = 0; m_stk.delete(); m_ovf = 1'b0; m_valid = 1'b1;
        end else begin
            ny = (m_y() + int'(ci)) & MASK;
            if (!fe_n) begin
                if (pup) begin
                    if (m_stk.size() < SD) m_stk.push_back(m_upc);
                    else begin m_stk[SD - 1] = m_upc; m_ovf = 1'b1; end
                end else begin
                    if (m_stk.size() > 0) void'(m_stk.pop_back());
                    else m_ovf = 1'b1;
                end
            end
            if (!ctl_n) m_r = int'(di);
            else if (!cte_n) m_r = (m_r - 1) & MASK;
            m_upc = ny;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_in(1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        tick();
    endtask

    initial begin
        do_reset();

        // Post-reset state and sequential fetch.
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1);
            chk("seq_y", int'(y), k);
            chk("seq_cz", int'(cz), 1);
            chk("seq_empty", int'(empty), 1);
            tick();
        end
        chk("rst_full", int'(full), 0);

        // Subroutine call at uPC=0x010 to 0x123, then return.
        set_in(1'b0, 3, 1'b1, 1'b0, 1'b1, 1'b1, 12'h010, 1'b0); tick();
        set_in(1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b1, 12'h123, 1'b1);
        chk("call_y", int'(y), 12'h123);
        tick();
        set_in(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("sub_y", int'(y), 12'h124);
        chk("sub_empty", int'(empty), 0);
        tick();
        set_in(1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("ret_y", int'(y), 12'h010);
        tick();
        set_in(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("ret_empty", int'(empty), 1);
        chk("ret_pc", int'(y), 12'h010);

        // Overflow: push 1..5, the fifth overwrites the top.
        do_reset();
        set_in(1'b0, 3, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0); tick();
        for (int v = 1; v <= 5; v++) begin
            set_in(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b1);
            tick();
            set_in(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
            if (v == 4) begin
                chk("ovf4_full", int'(full), 1);
                chk("ovf4_ovf", int'(ovf), 0);
            end
            if (v == 5) chk("ovf5_ovf", int'(ovf), 1);
        end
        begin
            int exp_pop[4] = '{5, 3, 2, 1};
            for (int k = 0; k < 4; k++) begin
                set_in(1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
                chk("pop_y", int'(y), exp_pop[k]);
                tick();
            end
        end
        set_in(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("pop_empty", int'(empty), 1);

        // Counter load then decrement through zero.
        set_in(1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h002, 1'b0); tick();
        begin
            int exp_r[4] = '{2, 1, 0, 12'hFFF};
            for (int k = 0; k < 4; k++) begin
                set_in(1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
                chk("cnt_r", int'(y), exp_r[k]);
                chk("cnt_cz", int'(cz), int'(k == 2));
                tick();
            end
        end

        // Load priority over decrement; pop on empty.
        set_in(1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h055, 1'b0); tick();
        set_in(1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("prio_r", int'(y), 12'h055);
        do_reset();
        set_in(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0); tick();
        set_in(1'b0, 2, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("uflow_ovf", int'(ovf), 1);
        chk("uflow_empty", int'(empty), 1);
        chk("uflow_top", int'(y), 0);

        // Reset mid-operation overrides push and load.
        set_in(1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b1, 12'h3A5, 1'b1); tick();
        set_in(1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0, 12'hABC, 1'b1); tick();
        set_in(1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("rmid_r", int'(y), 0);
        chk("rmid_cz", int'(cz), 1);
        chk("rmid_empty", int'(empty), 1);
        chk("rmid_ovf", int'(ovf), 0);
        set_in(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("rmid_pc", int'(y), 0);
        set_in(1'b0, 2, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("rmid_top", int'(y), 0);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 63) == 0, $urandom_range(0, 3),
                   $urandom_range(0, 2) != 0, $urandom_range(0, 1),
                   $urandom_range(0, 5) != 0, $urandom_range(0, 1) != 0,
                   $urandom_range(0, 15) == 0 ? $urandom_range(0, 2) : $urandom_range(0, MASK),
                   $urandom_range(0, 1));
            tick();
        end
        set_in(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
